// File: rtl/mesm6_icache.sv
// Direct-mapped instruction-word cache between the MESM-6 core instruction bus and memory.
// Zero-wait hits, bypassed miss data, optional sequential next-word prefetch, saturating counters.
module mesm6_icache #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 48,
    parameter int INDEX_W  = 4,
    parameter int PREFETCH = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ibus_fetch,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic [DATA_W-1:0] ibus_input,
    output logic              ibus_done,
    output logic              mem_fetch,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_input,
    input  logic              mem_done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int   ENTRIES = 1 << INDEX_W;
    localparam int   TAG_W   = ADDR_W - INDEX_W;
    localparam logic PF_EN   = (PREFETCH != 0);

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_PREF, S_PREF_MISS} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_W-1:0]    r_tag  [ENTRIES];
    logic [DATA_W-1:0]   r_data [ENTRIES];
    logic                r_mem_fetch;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_stale;
    logic [CNT_W-1:0]    r_hits;
    logic [CNT_W-1:0]    r_misses;

    logic [INDEX_W-1:0]  w_idx;
    logic [INDEX_W-1:0]  w_fidx;
    logic [ADDR_W-1:0]   w_dem1;
    logic [ADDR_W-1:0]   w_out1;
    logic                w_hit;
    logic                w_dmiss;
    logic                w_mdone;
    logic                w_same;
    logic                w_pres_dem1;
    logic                w_pres_out1;
    logic                w_demand_done;
    logic                w_issue;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic                w_fill;
    logic                w_cnt_miss;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_idx   = ibus_addr[INDEX_W-1:0];
    assign w_fidx  = r_mem_addr[INDEX_W-1:0];
    assign w_dem1  = ibus_addr + ADDR_W'(1);
    assign w_out1  = r_mem_addr + ADDR_W'(1);
    assign w_hit   = ibus_fetch & r_valid[w_idx] & (r_tag[w_idx] == ibus_addr[ADDR_W-1:INDEX_W]);
    assign w_dmiss = ibus_fetch & ~w_hit;
    // Only a reply to a request we still hold counts; stray replies after reset are dropped.
    assign w_mdone = mem_done & r_mem_fetch;
    assign w_same  = (ibus_addr == r_mem_addr);

    // A line being flushed this cycle is not worth skipping a prefetch for.
    assign w_pres_dem1 = ~flush & r_valid[w_dem1[INDEX_W-1:0]]
                         & (r_tag[w_dem1[INDEX_W-1:0]] == w_dem1[ADDR_W-1:INDEX_W]);
    assign w_pres_out1 = ~flush & r_valid[w_out1[INDEX_W-1:0]]
                         & (r_tag[w_out1[INDEX_W-1:0]] == w_out1[ADDR_W-1:INDEX_W]);

    assign w_demand_done = w_mdone & ((r_state == S_MISS)
                         | ((r_state == S_PREF) & w_dmiss & w_same));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_dmiss)                             w_next = S_MISS;
                else if (w_hit && PF_EN && !w_pres_dem1) w_next = S_PREF;
            end
            S_MISS: begin
                if (w_mdone) w_next = (PF_EN && !w_pres_out1) ? S_PREF : S_IDLE;
            end
            S_PREF: begin
                // Demand for the word already in flight simply adopts that request.
                if (w_dmiss && w_same)
                    w_next = w_mdone ? ((PF_EN && !w_pres_out1) ? S_PREF : S_IDLE) : S_MISS;
                else if (w_dmiss)
                    w_next = w_mdone ? S_MISS : S_PREF_MISS;
                else if (w_mdone)
                    w_next = S_IDLE;
            end
            S_PREF_MISS: begin
                if (w_mdone) w_next = S_MISS;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ibus_done    = w_hit | w_demand_done;
        ibus_input   = w_hit ? r_data[w_idx] : (w_demand_done ? mem_input : '0);
        w_issue      = (r_state == S_IDLE) ? (w_next != S_IDLE) : (w_mdone && (w_next != S_IDLE));
        w_issue_addr = (w_next == S_PREF) ? ((r_state == S_IDLE) ? w_dem1 : w_out1)
                                          : ((r_state == S_PREF_MISS) ? r_req_addr : ibus_addr);
        w_fill       = w_mdone && (r_state != S_IDLE);
        w_cnt_miss   = w_dmiss && ((r_state == S_IDLE) || (r_state == S_PREF));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_mem_fetch <= 1'b0;
            r_mem_addr  <= '0;
            r_stale     <= 1'b0;
            r_hits      <= '0;
            r_misses    <= '0;
        end else begin
            if (w_issue) begin
                r_mem_fetch <= 1'b1;
                r_mem_addr  <= w_issue_addr;
            end else if (w_mdone) begin
                r_mem_fetch <= 1'b0;
            end
            // A reply to a request issued before a flush may carry pre-flush memory contents.
            if (w_issue)    r_stale <= 1'b0;
            else if (flush) r_stale <= 1'b1;
            if (flush)       r_valid         <= '0;
            else if (w_fill) r_valid[w_fidx] <= ~r_stale;
            if (w_hit)      r_hits   <= f_sat_inc(r_hits);
            if (w_cnt_miss) r_misses <= f_sat_inc(r_misses);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= r_mem_addr[ADDR_W-1:INDEX_W];
            r_data[w_fidx] <= mem_input;
        end
        if (w_cnt_miss) r_req_addr <= ibus_addr;
    end

    assign mem_fetch  = r_mem_fetch;
    assign mem_addr   = r_mem_addr;
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

endmodule
